sobel_conv: RTL and testbench
=============================

SOBEL_CONV -- requirements
Module: sobel_conv

Interface
- REQ-001 SHALL have parameter THRESHOLD, default 4000: edge threshold applied to Gx^2+Gy^2.
- REQ-002 SHALL have parameter OUT_PIXELS, default 16383: number of output pixels per frame.
- REQ-003 SHALL have port Clk, input, 1: single clock; all state updates on rising edge.
- REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
- REQ-005 SHALL have port pixel_data_valid_in, input, 1: input window valid.
- REQ-006 SHALL have port pixel_data_in, input, 72: 3x3 window; pixel p(r,c) at bits [24r+8c+7 : 24r+8c], r,c in 0..2, unsigned 8-bit.
- REQ-007 SHALL have port ready_out, output, 1: window accepted this cycle when high together with pixel_data_valid_in; drives the window generator's dma_ready_in.
- REQ-008 SHALL have port out_ready_in, input, 1: downstream (DMA) ready.
- REQ-009 SHALL have port pixel_data_valid_out, output, 1: output pixel valid.
- REQ-010 SHALL have port pixel_data_out, output, 8: edge pixel, 8'hFF edge / 8'h00 no edge.
- REQ-011 SHALL have port frame_done, output, 1: one-cycle pulse on transfer of the last pixel of a frame.

Function
- REQ-012 SHALL implement a 3-stage pipeline with one global advance enable: adv = !v3 || out_ready_in, where v1..v3 are stage valid flags.
- REQ-013 SHALL drive ready_out = adv, combinationally.
- REQ-014 Stage 1 SHALL, on adv, capture v1 <= pixel_data_valid_in, plus signed 11-bit Gx = (p02+2*p12+p22)-(p00+2*p10+p20) and Gy = (p20+2*p21+p22)-(p00+2*p01+p02).
- REQ-015 Stage 2 SHALL, on adv, capture v2 <= v1 and unsigned 21-bit mag = Gx*Gx + Gy*Gy; maximum 2080800, no overflow.
- REQ-016 Stage 3 SHALL, on adv, capture v3 <= v2 and pixel = (mag > THRESHOLD) ? 8'hFF : 8'h00; equality SHALL give 8'h00.
- REQ-017 SHALL drive pixel_data_valid_out = v3 and pixel_data_out = the stage-3 register.
- REQ-018 Latency SHALL be 3 cycles: a window accepted at edge N appears at the output after edge N+2, provided out_ready_in stays high.
- REQ-019 With continuous valid and ready, throughput SHALL be 1 pixel/cycle.
- REQ-020 When adv=0, all stage registers SHALL hold their values; no window is accepted and none is lost or duplicated.
- REQ-021 Pipeline bubbles (v=0) SHALL propagate and be squeezed out while v3=0, even if out_ready_in=0.
- REQ-022 Output pixel order SHALL equal input window order.
- REQ-023 SHALL keep a 14-bit counter out_cnt of transfers (v3 && out_ready_in).
  - On a transfer with out_cnt == OUT_PIXELS-1: frame_done=1 for that cycle (combinational on the transfer) and out_cnt wraps to 0.
  - Otherwise the counter increments.
- REQ-024 Data-path registers of invalid stages SHALL be don't-care; only valid flags are observable.

Reset
- REQ-025 On rst_n low, asynchronously: v1,v2,v3 = 0; out_cnt = 0; pixel_data_out = 8'h00.
  - Therefore pixel_data_valid_out = 0, frame_done = 0, and ready_out = 1.
- REQ-026 Reset asserted mid-frame SHALL discard all in-flight pixels.
  - After reset release, the first transfer SHALL count as pixel 0 of a new frame.

Verification
- REQ-027 Uniform window (all pixels 8'h80), valid 1 cycle, out_ready_in=1 -> Gx=Gy=0; pixel_data_out=8'h00 with valid high 3 cycles later.
- REQ-028 Column 0 = 8'h00, column 2 = 8'hFF, column 1 = 8'h80 -> Gx=1020, Gy=0, mag=1040400; output 8'hFF.
- REQ-029 Column 0 = 0, column 2 = 8'h0A, column 1 = 5 -> mag=1600 <= 4000 gives 8'h00.
  - Column 2 = 8'h10, column 1 = 8 -> mag=4096 gives 8'hFF.
- REQ-030 Stream of 10 windows alternating edge/flat, out_ready_in low for 4 cycles mid-stream:
  - ready_out=0 while v3=1 and ready is low.
  - Exactly 10 outputs, in order, alternating FF/00; no loss or duplication.
- REQ-031 Run with OUT_PIXELS=4 and 9 windows -> frame_done pulses on transfers 4 and 8; counter ends at 1.
- REQ-032 Assert rst_n low with 2 pixels in flight -> valid_out drops immediately and no stale pixel emerges.
  - After release, frame_done fires on the OUT_PIXELS-th new transfer.

Source files
------------

// File: rtl/sobel_conv.sv
// Sobel edge detector: 3x3 window in, one thresholded edge pixel out.
// A 3-stage pipeline (gradients, magnitude, threshold) moves on a single advance enable.
module sobel_conv #(
   parameter int THRESHOLD  = 4000,
   parameter int OUT_PIXELS = 16383
) (
   input  logic        Clk,
   input  logic        rst_n,
   input  logic        pixel_data_valid_in,
   input  logic [71:0] pixel_data_in,
   output logic        ready_out,
   input  logic        out_ready_in,
   output logic        pixel_data_valid_out,
   output logic [7:0]  pixel_data_out,
   output logic        frame_done
);

   localparam logic [20:0] THRESH_MAG = 21'(THRESHOLD);
   localparam logic [13:0] LAST_CNT   = 14'(OUT_PIXELS - 1);

   logic               v1, v2, v3;
   logic               adv, xfer;
   logic [10:0]        p [3][3];
   logic signed [10:0] gx_d, gy_d, gx_q, gy_q;
   logic signed [20:0] gx_w, gy_w;
   logic [20:0]        mag_d, mag_q;
   logic [7:0]         pix_q;
   logic [13:0]        out_cnt;

   assign adv                  = !v3 || out_ready_in;
   assign ready_out            = adv;
   assign xfer                 = v3 && out_ready_in;
   assign frame_done           = xfer && (out_cnt == LAST_CNT);
   assign pixel_data_valid_out = v3;
   assign pixel_data_out       = pix_q;

   // Pixels are widened to 11 bits so the kernel sums and their difference
   // wrap into a correct two's-complement gradient in [-1020, 1020].
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            p[r][c] = {3'b000, pixel_data_in[24*r+8*c +: 8]};
         end
      end
      gx_d = (p[0][2] + (p[1][2] << 1) + p[2][2]) - (p[0][0] + (p[1][0] << 1) + p[2][0]);
      gy_d = (p[2][0] + (p[2][1] << 1) + p[2][2]) - (p[0][0] + (p[0][1] << 1) + p[0][2]);
   end

   // Each square fits in 21 bits; the sum is taken as unsigned 21-bit (max 2080800).
   always_comb begin
      gx_w  = {{10{gx_q[10]}}, gx_q};
      gy_w  = {{10{gy_q[10]}}, gy_q};
      mag_d = gx_w * gx_w + gy_w * gy_w;
   end

   always_ff @(posedge Clk) begin
      if (adv) begin
         gx_q  <= gx_d;
         gy_q  <= gy_d;
         mag_q <= mag_d;
      end
   end

   // Valid flags, output pixel and frame counter are the only reset state.
   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         v3      <= 1'b0;
         pix_q   <= 8'h00;
         out_cnt <= 14'd0;
      end else begin
         if (adv) begin
            v1    <= pixel_data_valid_in;
            v2    <= v1;
            v3    <= v2;
            pix_q <= (mag_q > THRESH_MAG) ? 8'hFF : 8'h00;
         end
         if (xfer) begin
            out_cnt <= (out_cnt == LAST_CNT) ? 14'd0 : out_cnt + 14'd1;
         end
      end
   end

endmodule

// File: tb/tb_sobel_conv.sv
// Directed bench for sobel_conv with a scoreboard of expected edge pixels.
// Runs with OUT_PIXELS=4 so frame boundaries come around quickly.
module tb_sobel_conv;

   localparam int FRAME = 4;

   logic        Clk;
   logic        rst_n;
   logic        pixel_data_valid_in;
   logic [71:0] pixel_data_in;
   logic        ready_out;
   logic        out_ready_in;
   logic        pixel_data_valid_out;
   logic [7:0]  pixel_data_out;
   logic        frame_done;

   int          compared   = 0;
   int          mismatched = 0;
   logic [7:0]  sb[$];
   int          model_cnt  = 0;
   int          out_total  = 0;
   int          pulses     = 0;

   sobel_conv #(.THRESHOLD(4000), .OUT_PIXELS(FRAME)) dut (
      .Clk                  (Clk),
      .rst_n                (rst_n),
      .pixel_data_valid_in  (pixel_data_valid_in),
      .pixel_data_in        (pixel_data_in),
      .ready_out            (ready_out),
      .out_ready_in         (out_ready_in),
      .pixel_data_valid_out (pixel_data_valid_out),
      .pixel_data_out       (pixel_data_out),
      .frame_done           (frame_done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference convolution written directly from the kernel coefficients.
   function automatic logic [7:0] refPixel(input logic [71:0] w);
      int kx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
      int ky [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
      int gx = 0;
      int gy = 0;
      int pv;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            pv = int'(w[24*r+8*c +: 8]);
            gx += kx[r][c] * pv;
            gy += ky[r][c] * pv;
         end
      end
      return (gx * gx + gy * gy > 4000) ? 8'hFF : 8'h00;
   endfunction

   function automatic logic [71:0] colWindow(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
      logic [71:0] w;
      for (int r = 0; r < 3; r++) begin
         w[24*r +: 8]    = c0;
         w[24*r+8 +: 8]  = c1;
         w[24*r+16 +: 8] = c2;
      end
      return w;
   endfunction

   // Scoreboard: accepted windows push their reference pixel, transfers pop and compare.
   always @(negedge Clk) begin
      if (rst_n) begin
         if (pixel_data_valid_out && out_ready_in) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_output", 32'd1, 32'd0);
            end else begin
               checkOutput("pixel", {24'd0, pixel_data_out}, {24'd0, sb.pop_front()});
            end
            checkOutput("frame_done_xfer", {31'd0, frame_done}, {31'd0, model_cnt == FRAME - 1});
            model_cnt = (model_cnt == FRAME - 1) ? 0 : model_cnt + 1;
            out_total++;
            if (frame_done) pulses++;
         end else begin
            checkOutput("frame_done_idle", {31'd0, frame_done}, 32'd0);
         end
         if (pixel_data_valid_in && ready_out) begin
            sb.push_back(refPixel(pixel_data_in));
         end
      end
   end

   task automatic applyStimulus(input logic [71:0] w, output int waits);
      pixel_data_in       = w;
      pixel_data_valid_in = 1'b1;
      waits = 0;
      do begin
         @(negedge Clk);
         waits++;
      end while (!ready_out && waits < 50);
      if (!ready_out) checkOutput("accept_timeout", 32'd1, 32'd0);
      @(posedge Clk);
      #1;
      pixel_data_valid_in = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge Clk);
         n++;
      end
      checkOutput("drain_left", sb.size(), 32'd0);
      repeat (3) @(posedge Clk);
      #1;
   endtask

   initial begin
      logic [71:0] w;
      int          waits;
      int          total;
      int          base;

      rst_n               = 1'b0;
      pixel_data_valid_in = 1'b0;
      pixel_data_in       = '0;
      out_ready_in        = 1'b0;
      #23;
      checkOutput("rst_valid_out", {31'd0, pixel_data_valid_out}, 32'd0);
      checkOutput("rst_frame_done", {31'd0, frame_done}, 32'd0);
      checkOutput("rst_ready_out", {31'd0, ready_out}, 32'd1);
      checkOutput("rst_pixel", {24'd0, pixel_data_out}, 32'h00);
      @(posedge Clk);
      #1;
      rst_n        = 1'b1;
      out_ready_in = 1'b1;

      // Uniform window: flat output after exactly three edges.
      pixel_data_in       = colWindow(8'h80, 8'h80, 8'h80);
      pixel_data_valid_in = 1'b1;
      @(posedge Clk);
      #1;
      pixel_data_valid_in = 1'b0;
      @(negedge Clk);
      checkOutput("lat_edge_n", {31'd0, pixel_data_valid_out}, 32'd0);
      @(negedge Clk);
      checkOutput("lat_edge_n1", {31'd0, pixel_data_valid_out}, 32'd0);
      @(negedge Clk);
      checkOutput("lat_edge_n2", {31'd0, pixel_data_valid_out}, 32'd1);
      checkOutput("uniform_pix", {24'd0, pixel_data_out}, 32'h00);
      drain();

      // Strong vertical edge, below threshold, above threshold, exactly at threshold.
      applyStimulus(colWindow(8'h00, 8'h80, 8'hFF), waits);
      applyStimulus(colWindow(8'h00, 8'h05, 8'h0A), waits);
      applyStimulus(colWindow(8'h00, 8'h08, 8'h10), waits);
      w = colWindow(8'h00, 8'h05, 8'h0F);
      w[24*2+8 +: 8] = 8'h0F;
      applyStimulus(w, waits);
      drain();
      checkOutput("thresh_count", out_total, 32'd5);

      // Alternating stream with a four-cycle downstream stall in the middle.
      base = out_total;
      for (int i = 0; i < 10; i++) begin
         if (i == 5) begin
            pixel_data_in       = colWindow(8'h00, 8'h80, 8'hFF);
            pixel_data_valid_in = 1'b1;
            out_ready_in        = 1'b0;
            repeat (4) begin
               @(negedge Clk);
               checkOutput("stall_ready_out", {31'd0, ready_out}, 32'd0);
            end
            @(posedge Clk);
            #1;
            out_ready_in = 1'b1;
         end
         w = (i % 2 == 0) ? colWindow(8'hFF, 8'h80, 8'h00) : colWindow(8'h40, 8'h40, 8'h40);
         applyStimulus(w, waits);
      end
      drain();
      checkOutput("stream_count", out_total - base, 32'd10);

      // Reset with two windows in flight; realign the frame counter first.
      rst_n = 1'b0;
      sb.delete();
      model_cnt = 0;
      #4;
      rst_n = 1'b1;
      @(posedge Clk);
      #1;
      applyStimulus(colWindow(8'h00, 8'h80, 8'hFF), waits);
      applyStimulus(colWindow(8'h00, 8'h80, 8'hFF), waits);
      rst_n = 1'b0;
      sb.delete();
      model_cnt = 0;
      #1;
      checkOutput("midrst_valid_out", {31'd0, pixel_data_valid_out}, 32'd0);
      checkOutput("midrst_pixel", {24'd0, pixel_data_out}, 32'h00);
      @(posedge Clk);
      #1;
      rst_n = 1'b1;
      base = out_total;
      repeat (6) @(posedge Clk);
      #1;
      checkOutput("no_stale_output", out_total - base, 32'd0);

      // Nine back-to-back windows: frame_done on transfers 4 and 8, one pending.
      pulses = 0;
      total  = 0;
      for (int i = 0; i < 9; i++) begin
         w = (i % 3 == 0) ? colWindow(8'h00, 8'h80, 8'hFF) : colWindow(8'h10, 8'h10, 8'h10);
         applyStimulus(w, waits);
         total += waits;
      end
      checkOutput("throughput_cycles", total, 32'd9);
      drain();
      checkOutput("frame_pulses_9", pulses, 32'd2);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(colWindow(8'h20, 8'h20, 8'h20), waits);
      end
      drain();
      checkOutput("frame_pulses_12", pulses, 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
